traffic_lanes: RTL and testbench
================================

# traffic_lanes

Parametrised traffic generator for the crossing game. It holds the column position of one car per lane for `NUM_LANES` lanes. Each lane has its own row, direction, start column and speed divider, and the movement rate speeds up with the current level. It checks for player collisions and flags them with a registered pulse. It also answers a zero-latency "is there a car at cell (x,y)" query for the VGA pixel path. It sits between the player/level logic and the renderer, and replaces the fixed per-car instances.

## Interface
- `NUM_LANES`, 11: number of lanes, one car per lane, 1..15.
- `GRID_W`, 20: columns per row. Car x is always in 0..GRID_W-1.
- `X_W`, 5: column width, with 2^X_W ≥ GRID_W.
- `Y_W`, 4: row width.
- `CNT_W`, 25: width of the tick divider.
- `BASE_PERIOD`, 25_000_000: clocks per global tick at level 0.
- `PERIOD_STEP`, 200_000: period reduction per level.
- `MIN_PERIOD`, 2_000_000: floor for the period, ≥ 2.
- `LANE_ROW`, packed NUM_LANES×Y_W: row of lane i, in bits [i*Y_W +: Y_W].
- `LANE_DIR`, packed NUM_LANES×1: 0 moves right (+1), 1 moves left (−1).
- `LANE_START`, packed NUM_LANES×X_W: reset/restart column of lane i.
- `LANE_DIV`, packed NUM_LANES×2: lane i moves every LANE_DIV[i]+1 global ticks.

Ports:
- `i_Clk`, in, 1: clock.
- `i_reset`, in, 1: asynchronous, active-high reset.
- `i_restart`, in, 1: synchronous one-cycle pulse that reloads start positions.
- `i_freeze`, in, 1: while high, all counters and positions hold.
- `i_level`, in, 7: current level, 0..99.
- `i_player_x`, in, X_W: player column.
- `i_player_y`, in, Y_W: player row.
- `i_query_x`, in, X_W: renderer cell column.
- `i_query_y`, in, Y_W: renderer cell row.
- `o_query_hit`, out, 1: combinational; high when a car occupies the query cell.
- `o_car_x`, out, NUM_LANES×X_W: registered car columns, packed like `LANE_START`.
- `o_collision`, out, 1: registered one-cycle pulse on a new player/car overlap.
- `o_hit_lane`, out, 4: index of the lowest-numbered overlapping lane, valid with `o_collision`.
- `o_tick`, out, 1: registered one-cycle pulse on every global tick.

## Operation
- **Period calculation**
  - `period` = max(MIN_PERIOD, BASE_PERIOD − i_level×PERIOD_STEP).
  - The product is computed in CNT_W+7 bits, and any underflow saturates to MIN_PERIOD.
  - `period` is registered each cycle, but the divider only samples it when the divider wraps. A level change never truncates or extends a running count beyond one tick.
- **Global divider**
  - `div_cnt` counts 0..period−1.
  - At period−1 it returns to 0 and raises the internal `tick` and `o_tick` for that cycle.
- **Per-lane sub-counter**
  - Each lane has a 2-bit `sub[i]`.
  - On `tick`: if sub[i]==LANE_DIV[i], then sub[i]←0 and the lane moves. Otherwise sub[i]←sub[i]+1.
- **Lane movement**
  - Right-moving lanes: x==GRID_W−1 wraps to 0, otherwise x+1.
  - Left-moving lanes: x==0 wraps to GRID_W−1, otherwise x−1.
  - Arithmetic is X_W bits, and x never leaves 0..GRID_W−1.
- **Overlap**
  - `overlap` = OR over lanes of (o_car_x[i]==i_player_x && LANE_ROW[i]==i_player_y), using the current registered positions.
  - `o_collision` ← overlap && !overlap_d, where overlap_d is the previous cycle's overlap. A player sitting on a car gives exactly one pulse.
  - `o_hit_lane` is registered alongside `o_collision`: the lowest i that overlaps. It holds its last value otherwise.
- **Query**
  - Same comparison as overlap, but against i_query_x/y. Purely combinational, with no clock dependence.
- **Priority, highest first**
  - `i_reset`: asynchronous.
  - `i_restart`: positions ← LANE_START, div_cnt←0, sub←0, overlap_d←0.
  - `i_freeze`: everything holds, and o_tick, o_collision = 0.
  - Normal operation.
- **Reset values**
  - o_car_x = LANE_START.
  - div_cnt = 0, sub = 0, period = BASE_PERIOD.
  - o_collision = 0, o_hit_lane = 0, o_tick = 0, overlap_d = 0.

## Timing
- Movement latency:
  - `tick` occurs in the cycle where div_cnt==period−1.
  - o_car_x updates on that same clock edge, so the new positions are visible the following cycle, together with o_tick=1.
- Collision latency: o_collision rises one cycle after the cycle in which the registered positions and the player inputs first overlap.
- Restart in the same cycle as a tick: the restart wins, no move is applied, and o_tick = 0.
- Freeze released: counting resumes from the held div_cnt, with no lost or extra tick.
- Reset asserted mid-count: all state returns to its reset value immediately. The first tick after reset release comes exactly BASE_PERIOD cycles later when i_level = 0.
- Two lanes on the same row: this is legal. Query and overlap OR them together.

## Test plan
Bench parameters: GRID_W=20, BASE_PERIOD=10, PERIOD_STEP=2, MIN_PERIOD=3, NUM_LANES=2. Lane0 is row 2, right, start 18, div 0. Lane1 is row 3, left, start 1, div 1.

1. **Reset and first tick:** release reset with level 0, count 10 clocks → o_tick once; lane0 = 19, lane1 = 1, sub1 = 1.
2. **Wrap-around and divider:** after the next tick → lane0 = 0 (wrap), lane1 = 0. After one more tick → lane0 = 1, lane1 = 0. After the tick after that → lane1 = 19 (wrap).
3. **Level speed-up:** level=3 → ticks every 4 clocks after the current count completes. Level=50 → ticks every 3 clocks (saturated at MIN_PERIOD).
4. **Collision:** player (0,2) held while lane0 moves 19→0 → exactly one o_collision pulse one cycle later with o_hit_lane=0. No further pulse while the player is held; a new pulse after a separate, new overlap.
5. **Restart vs tick:** i_restart asserted in the div_cnt==9 cycle → positions 18/1, o_tick=0, next tick 10 clocks later.
6. **Freeze and query:** freeze 25 clocks → positions and o_tick unchanged. Query (18,2) → hit=1 and (18,3) → 0 in the same cycle.

Source files
------------

// File: rtl/traffic_lanes.sv
// Lane-based car generator for the crossing game. It moves one car per lane on a level-scaled
// global tick, reports player collisions and answers cell-occupancy queries from the renderer.
module traffic_lanes #(
    parameter int NUM_LANES   = 11,
    parameter int GRID_W      = 20,
    parameter int X_W         = 5,
    parameter int Y_W         = 4,
    parameter int CNT_W       = 25,
    parameter int BASE_PERIOD = 25_000_000,
    parameter int PERIOD_STEP = 200_000,
    parameter int MIN_PERIOD  = 2_000_000,
    parameter logic [NUM_LANES*Y_W-1:0] LANE_ROW   = 44'hBA987654321,
    parameter logic [NUM_LANES-1:0]     LANE_DIR   = 11'b10101010101,
    parameter logic [NUM_LANES*X_W-1:0] LANE_START = '0,
    parameter logic [NUM_LANES*2-1:0]   LANE_DIV   = '0
) (
    input  logic                     i_Clk,
    input  logic                     i_reset,
    input  logic                     i_restart,
    input  logic                     i_freeze,
    input  logic [6:0]               i_level,
    input  logic [X_W-1:0]           i_player_x,
    input  logic [Y_W-1:0]           i_player_y,
    input  logic [X_W-1:0]           i_query_x,
    input  logic [Y_W-1:0]           i_query_y,
    output logic                     o_query_hit,
    output logic [NUM_LANES*X_W-1:0] o_car_x,
    output logic                     o_collision,
    output logic [3:0]               o_hit_lane,
    output logic                     o_tick
);

    localparam int PW = CNT_W + 7;

    logic [PW-1:0]    prod;
    logic [PW-1:0]    diff;
    logic [CNT_W-1:0] period_d, period_q;
    logic [CNT_W-1:0] act_period_d, act_period_q;
    logic [CNT_W-1:0] div_cnt_d, div_cnt_q;
    logic             wrap;
    logic             tick;

    logic [NUM_LANES-1:0] ovl_hit;
    logic [NUM_LANES-1:0] qry_hit;
    logic                 overlap;
    logic                 overlap_d_d, overlap_d_q;
    logic                 collision_d, collision_q;
    logic [3:0]           hit_lane_d, hit_lane_q;
    logic [3:0]           lowest;
    logic                 tick_q;

    // Level-scaled period, saturating at the floor when the subtraction would underflow.
    always_comb begin
        prod     = PW'(i_level) * PW'(PERIOD_STEP);
        diff     = PW'(BASE_PERIOD) - prod;
        period_d = CNT_W'(MIN_PERIOD);
        if (prod < PW'(BASE_PERIOD) && diff > PW'(MIN_PERIOD))
            period_d = diff[CNT_W-1:0];
    end

    // The running count uses act_period, which only picks up a new period at a wrap.
    always_comb begin
        wrap         = (div_cnt_q == act_period_q - CNT_W'(1));
        tick         = wrap && !i_restart && !i_freeze;
        div_cnt_d    = div_cnt_q;
        act_period_d = act_period_q;
        if (i_restart) begin
            div_cnt_d    = '0;
            act_period_d = period_q;
        end else if (!i_freeze) begin
            if (wrap) begin
                div_cnt_d    = '0;
                act_period_d = period_q;
            end else begin
                div_cnt_d = div_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) begin
            period_q     <= CNT_W'(BASE_PERIOD);
            act_period_q <= CNT_W'(BASE_PERIOD);
            div_cnt_q    <= '0;
        end else begin
            period_q     <= period_d;
            act_period_q <= act_period_d;
            div_cnt_q    <= div_cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [X_W-1:0] x_d, x_q;
            logic [X_W-1:0] x_step;
            logic [1:0]     sub_d, sub_q;

            always_comb begin
                if (LANE_DIR[gi])
                    x_step = (x_q == '0) ? X_W'(GRID_W - 1) : x_q - X_W'(1);
                else
                    x_step = (x_q == X_W'(GRID_W - 1)) ? '0 : x_q + X_W'(1);

                x_d   = x_q;
                sub_d = sub_q;
                if (i_restart) begin
                    x_d   = LANE_START[gi*X_W +: X_W];
                    sub_d = '0;
                end else if (tick) begin
                    if (sub_q == LANE_DIV[gi*2 +: 2]) begin
                        sub_d = '0;
                        x_d   = x_step;
                    end else begin
                        sub_d = sub_q + 2'd1;
                    end
                end
            end

            always_ff @(posedge i_Clk or posedge i_reset) begin
                if (i_reset) begin
                    x_q   <= LANE_START[gi*X_W +: X_W];
                    sub_q <= '0;
                end else begin
                    x_q   <= x_d;
                    sub_q <= sub_d;
                end
            end

            assign o_car_x[gi*X_W +: X_W] = x_q;
            assign ovl_hit[gi] = (x_q == i_player_x) && (LANE_ROW[gi*Y_W +: Y_W] == i_player_y);
            assign qry_hit[gi] = (x_q == i_query_x)  && (LANE_ROW[gi*Y_W +: Y_W] == i_query_y);
        end
    endgenerate

    assign overlap     = |ovl_hit;
    assign o_query_hit = |qry_hit;

    always_comb begin
        lowest = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--)
            if (ovl_hit[i]) lowest = 4'(i);
    end

    // Edge-detect the overlap so a player parked on a car produces a single pulse.
    always_comb begin
        overlap_d_d = overlap_d_q;
        collision_d = 1'b0;
        hit_lane_d  = hit_lane_q;
        if (i_restart) begin
            overlap_d_d = 1'b0;
        end else if (!i_freeze) begin
            overlap_d_d = overlap;
            if (overlap && !overlap_d_q) begin
                collision_d = 1'b1;
                hit_lane_d  = lowest;
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) begin
            overlap_d_q <= 1'b0;
            collision_q <= 1'b0;
            hit_lane_q  <= '0;
            tick_q      <= 1'b0;
        end else begin
            overlap_d_q <= overlap_d_d;
            collision_q <= collision_d;
            hit_lane_q  <= hit_lane_d;
            tick_q      <= tick;
        end
    end

    assign o_collision = collision_q;
    assign o_hit_lane  = hit_lane_q;
    assign o_tick      = tick_q;

endmodule

// File: tb/tb_traffic_lanes.sv
// Directed bench for traffic_lanes with two lanes and a short base period.
module tb_traffic_lanes;

    logic       clk = 1'b0;
    logic       rst;
    logic       restart;
    logic       freeze;
    logic [6:0] level;
    logic [4:0] player_x, query_x;
    logic [3:0] player_y, query_y;
    logic       query_hit;
    logic [9:0] car_x;
    logic       collision;
    logic [3:0] hit_lane;
    logic       tick;

    int checks   = 0;
    int failures = 0;
    int last_colls;
    int frz_ticks;

    always #5 clk = ~clk;

    traffic_lanes #(
        .NUM_LANES(2), .GRID_W(20), .X_W(5), .Y_W(4), .CNT_W(8),
        .BASE_PERIOD(10), .PERIOD_STEP(2), .MIN_PERIOD(3),
        .LANE_ROW(8'h32), .LANE_DIR(2'b10),
        .LANE_START(10'b00001_10010), .LANE_DIV(4'b0100)
    ) dut (
        .i_Clk(clk), .i_reset(rst), .i_restart(restart), .i_freeze(freeze),
        .i_level(level), .i_player_x(player_x), .i_player_y(player_y),
        .i_query_x(query_x), .i_query_y(query_y), .o_query_hit(query_hit),
        .o_car_x(car_x), .o_collision(collision), .o_hit_lane(hit_lane), .o_tick(tick)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
        $display("check %-18s got=%0d exp=%0d", tag, got, exp);
    endtask

    // Advance until o_tick is seen (bounded); checks the number of clocks it took.
    task automatic run_to_tick(input string tag, input int exp_n);
        int n;
        int colls;
        n = 0;
        colls = 0;
        do begin
            @(negedge clk);
            n++;
            if (collision) colls++;
        end while (!tick && n < 60);
        last_colls = colls;
        chk(tag, n, exp_n);
    endtask

    initial begin
        rst = 1'b1; restart = 1'b0; freeze = 1'b0; level = 7'd0;
        player_x = 5'd5; player_y = 4'd9; query_x = 5'd0; query_y = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_lane0", int'(car_x[4:0]), 18);
        chk("rst_lane1", int'(car_x[9:5]), 1);
        chk("rst_tick", int'(tick), 0);
        chk("rst_coll", int'(collision), 0);
        chk("rst_hit_lane", int'(hit_lane), 0);

        // First tick after reset release
        rst = 1'b0;
        run_to_tick("tick1_period", 10);
        chk("tick1_lane0", int'(car_x[4:0]), 19);
        chk("tick1_lane1", int'(car_x[9:5]), 1);

        // Wrap and collision on lane0 moving 19->0
        player_x = 5'd0; player_y = 4'd2;
        run_to_tick("tick2_period", 10);
        chk("tick2_lane0_wrap", int'(car_x[4:0]), 0);
        chk("tick2_lane1", int'(car_x[9:5]), 0);
        chk("coll_not_yet", int'(collision), 0);
        @(negedge clk);
        chk("coll_pulse", int'(collision), 1);
        chk("coll_lane0", int'(hit_lane), 0);
        @(negedge clk);
        chk("coll_once", int'(collision), 0);
        run_to_tick("tick3_period", 8);
        chk("no_repeat_coll", last_colls, 0);
        chk("tick3_lane0", int'(car_x[4:0]), 1);
        chk("tick3_lane1", int'(car_x[9:5]), 0);
        @(negedge clk);
        player_x = 5'd1;
        @(negedge clk);
        chk("coll_new", int'(collision), 1);
        player_x = 5'd5; player_y = 4'd9;
        run_to_tick("tick4_period", 8);
        chk("tick4_lane0", int'(car_x[4:0]), 2);
        chk("tick4_lane1_wrap", int'(car_x[9:5]), 19);

        // Lane1 collision, plus level speed-up
        player_x = 5'd19; player_y = 4'd3;
        level = 7'd3;
        @(negedge clk);
        chk("coll_lane1", int'(collision), 1);
        chk("hit_lane1", int'(hit_lane), 1);
        player_x = 5'd5; player_y = 4'd9;
        run_to_tick("lvl3_finish_cur", 9);
        run_to_tick("lvl3_period_a", 4);
        run_to_tick("lvl3_period_b", 4);
        level = 7'd50;
        run_to_tick("lvl50_finish_cur", 4);
        run_to_tick("lvl50_sat_a", 3);
        run_to_tick("lvl50_sat_b", 3);
        level = 7'd0;
        run_to_tick("lvl0_finish_cur", 3);
        run_to_tick("lvl0_period", 10);
        chk("tick12_lane0", int'(car_x[4:0]), 10);
        chk("tick12_lane1", int'(car_x[9:5]), 15);

        // Restart in the tick cycle
        repeat (9) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("restart_no_tick", int'(tick), 0);
        chk("restart_lane0", int'(car_x[4:0]), 18);
        chk("restart_lane1", int'(car_x[9:5]), 1);
        query_x = 5'd18; query_y = 4'd2;
        #1 chk("query_18_2", int'(query_hit), 1);
        query_y = 4'd3;
        #1 chk("query_18_3", int'(query_hit), 0);
        query_x = 5'd1;
        #1 chk("query_1_3", int'(query_hit), 1);
        run_to_tick("restart_period", 10);
        chk("post_rst_lane0", int'(car_x[4:0]), 19);

        // Freeze mid-count
        repeat (4) @(negedge clk);
        freeze = 1'b1;
        frz_ticks = 0;
        repeat (25) begin
            @(negedge clk);
            if (tick) frz_ticks++;
        end
        chk("freeze_ticks", frz_ticks, 0);
        chk("freeze_lane0", int'(car_x[4:0]), 19);
        chk("freeze_lane1", int'(car_x[9:5]), 1);
        freeze = 1'b0;
        run_to_tick("unfreeze_remain", 6);
        chk("unfrz_lane0", int'(car_x[4:0]), 0);
        chk("unfrz_lane1", int'(car_x[9:5]), 0);

        // Asynchronous reset mid-count
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1 chk("async_rst_lane0", int'(car_x[4:0]), 18);
        chk("async_rst_lane1", int'(car_x[9:5]), 1);
        @(negedge clk);
        rst = 1'b0;
        run_to_tick("post_reset_period", 10);
        chk("post_reset_lane0", int'(car_x[4:0]), 19);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
